// File: rtl/clock24_pkg.sv
// Shared definitions for the 24-hour clock family controllers.
// Provides the FSM state encoding and the counter width helper.
package clock24_pkg;

   localparam int STATE_W = 2;

   // One-hot encoding, so that an all-zero or all-one register is detectably illegal.
   typedef enum logic [STATE_W-1:0] {
      NORM = 2'b01,
      ADJ  = 2'b10
   } state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/repeat_timer.sv
// Auto-repeat timer for the ADJUST button: a down-counter that fires once
// REPEAT_DLY cycles after arming, then every REPEAT_PER cycles (REPEAT_DLY >= 2).
module repeat_timer
   import clock24_pkg::*;
#(
   parameter int REPEAT_DLY = 8,
   parameter int REPEAT_PER = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arm,
   input  logic disarm,
   output logic fire,
   output logic armed
);

   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CNT_W   = cnt_width(CNT_MAX);

   logic [CNT_W-1:0] cnt;

   // Terminal count is 1 so that fire, being registered, lands on the exact cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
         fire  <= 1'b0;
         cnt   <= '0;
      end else begin
         fire <= 1'b0;
         if (disarm) begin
            armed <= 1'b0;
            cnt   <= '0;
         end else if (arm) begin
            armed <= 1'b1;
            cnt   <= CNT_W'(REPEAT_DLY - 1);
         end else if (armed) begin
            if (cnt == CNT_W'(1)) begin
               fire <= 1'b1;
               cnt  <= CNT_W'(REPEAT_PER);
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/clock_adjust_fsm.sv
// Time-setting controller: normal/adjust mode, field select, clear/increment strobes.
// Define AUTOREPEAT_EN to build the ADJUST auto-repeat timer.
//
//   state | meaning
//   NORM  | clock running, all fields displayed, buttons other than MODE ignored
//   ADJ   | field SEL selected for setting and blinking
module clock_adjust_fsm
   import clock24_pkg::*;
#(
   parameter int                NFIELD     = 3,
   parameter logic [NFIELD-1:0] CLRMASK    = NFIELD'(1),
   parameter int                TIMEOUT    = 0,
   parameter int                REPEAT_DLY = 8,
   parameter int                REPEAT_PER = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      SIG2HZ,
   input  logic                      MODE,
   input  logic                      SELECT,
   input  logic                      ADJUST,
   input  logic                      ADJLVL,
   output logic [NFIELD-1:0]         INC,
   output logic [NFIELD-1:0]         CLR,
   output logic [NFIELD-1:0]         ON,
   output logic [$clog2(NFIELD)-1:0] SEL,
   output logic                      ADJACT
);

   localparam int SEL_W  = $clog2(NFIELD);
   localparam int IDLE_W = cnt_width(TIMEOUT);

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  sel, sel_nxt;
   logic [IDLE_W-1:0] idle_cnt;
   logic [NFIELD-1:0] sel_hot;
   logic              in_adj, active, timeout_hit;
   logic              rpt, rpt_armed, strobe, clr_sel;

   assign in_adj      = (state == ADJ);
   assign active      = MODE | SELECT | ADJUST | ADJLVL;
   assign timeout_hit = (TIMEOUT > 0) && in_adj && !active &&
                        (idle_cnt == IDLE_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      case (state)
         NORM: begin
            if (MODE) begin
               state_nxt = ADJ;
               sel_nxt   = '0;
            end
         end
         ADJ: begin
            if (MODE)
               state_nxt = NORM;
            else if (SELECT)
               sel_nxt = (sel == '0) ? SEL_W'(NFIELD - 1) : sel - 1'b1;
            else if (timeout_hit)
               state_nxt = NORM;
         end
         default: state_nxt = NORM;
      endcase
   end

   // Idle counter saturates at TIMEOUT and is held at zero outside adjust mode.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= NORM;
         sel      <= '0;
         idle_cnt <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         if (!in_adj || active)
            idle_cnt <= '0;
         else if (idle_cnt != IDLE_W'(TIMEOUT))
            idle_cnt <= idle_cnt + 1'b1;
      end
   end

`ifdef AUTOREPEAT_EN
   repeat_timer #(
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
   ) u_repeat_timer (
      .clk   (CLK),
      .rst   (RST),
      .arm   (in_adj & ADJUST),
      .disarm(~ADJLVL | MODE | SELECT | timeout_hit | ~in_adj),
      .fire  (rpt),
      .armed (rpt_armed)
   );
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = (REPEAT_DLY > REPEAT_PER);
   assign rpt       = 1'b0;
   assign rpt_armed = 1'b0;
`endif

   always_comb begin
      sel_hot = '0;
      for (int i = 0; i < NFIELD; i++)
         sel_hot[i] = (sel == SEL_W'(i));
   end

   // A manual ADJUST and a repeat fire in the same cycle merge into one strobe.
   assign clr_sel = |(sel_hot & CLRMASK);
   assign strobe  = in_adj & ~MODE & ~SELECT & (ADJUST | rpt);
   assign CLR     = (strobe &  clr_sel) ? sel_hot : '0;
   assign INC     = (strobe & ~clr_sel) ? sel_hot : '0;
   assign ON      = ~(sel_hot & {NFIELD{in_adj & SIG2HZ & ~rpt_armed}});
   assign SEL     = sel;
   assign ADJACT  = in_adj;

endmodule

// File: tb/tb_clock_adjust_fsm.sv
// Scoreboard bench for clock_adjust_fsm (NFIELD=3, CLRMASK=001, TIMEOUT=32).
// Expected outputs are queued per driven cycle and compared on the falling edge.
module tb_clock_adjust_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sig2hz = 1'b0, mode = 1'b0, select = 1'b0, adjust = 1'b0, adjlvl = 1'b0;
   logic [2:0] inc, clr, on;
   logic [1:0] sel;
   logic       adjact;
   int         n_chk = 0;
   int         n_pass = 0;

`ifdef AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]  inc;
      logic [2:0]  clr;
      logic [2:0]  on;
      logic [1:0]  sel;
      logic        act;
      logic [63:0] name;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   clock_adjust_fsm #(
      .NFIELD    (3),
      .CLRMASK   (3'b001),
      .TIMEOUT   (32),
      .REPEAT_DLY(8),
      .REPEAT_PER(4)
   ) dut (
      .CLK   (clk),
      .RST   (rst),
      .SIG2HZ(sig2hz),
      .MODE  (mode),
      .SELECT(select),
      .ADJUST(adjust),
      .ADJLVL(adjlvl),
      .INC   (inc),
      .CLR   (clr),
      .ON    (on),
      .SEL   (sel),
      .ADJACT(adjact)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic drive(input logic r, m, s, a, l, h,
                        input logic [2:0] e_inc, e_clr, e_on,
                        input logic [1:0] e_sel, input logic e_act,
                        input logic [63:0] name);
      @(posedge clk);
      #1;
      rst = r; mode = m; select = s; adjust = a; adjlvl = l; sig2hz = h;
      sb.push_back('{e_inc, e_clr, e_on, e_sel, e_act, name});
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk($sformatf("%0s.inc", e.name), inc, e.inc);
         chk($sformatf("%0s.clr", e.name), clr, e.clr);
         chk($sformatf("%0s.on", e.name), on, e.on);
         chk($sformatf("%0s.sel", e.name), sel, e.sel);
         chk($sformatf("%0s.act", e.name), adjact, e.act);
      end
   end

   initial begin
      #2 rst = 1'b1;
      //    r  m  s  a  l  h   inc     clr     on      sel    act
      drive(1, 1, 0, 1, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "rst_a");
      drive(1, 0, 0, 1, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "rst_b");
      drive(0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "idle");
      drive(0, 0, 0, 1, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "norm_adj");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "norm_sel");
      drive(0, 1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "mode_in");
      drive(0, 0, 0, 1, 0, 0, 3'b000, 3'b001, 3'b111, 2'd0, 1'b1, "clr_f0");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b1, "sel_a");
      drive(0, 0, 0, 1, 0, 0, 3'b100, 3'b000, 3'b111, 2'd2, 1'b1, "inc_f2");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd2, 1'b1, "sel_b");
      drive(0, 0, 0, 1, 0, 0, 3'b010, 3'b000, 3'b111, 2'd1, 1'b1, "inc_f1");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd1, 1'b1, "sel_c");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b1, "sel_wrap");
      drive(0, 1, 1, 1, 0, 0, 3'b000, 3'b000, 3'b111, 2'd2, 1'b1, "mode_all");
      drive(0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b111, 2'd2, 1'b0, "norm_blk");
      drive(0, 1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd2, 1'b0, "mode_in2");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b1, "sel_d");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd2, 1'b1, "sel_e");

      // Field 1 blinks while idle; the 32nd idle cycle is the last one in adjust mode.
      for (int k = 1; k <= 32; k++)
         drive(0, 0, 0, 0, 0, k[0], 3'b000, 3'b000, k[0] ? 3'b101 : 3'b111, 2'd1, 1'b1, "idle_adj");
      drive(0, 0, 0, 0, 0, 1, 3'b000, 3'b000, 3'b111, 2'd1, 1'b0, "timeout");

      drive(0, 1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd1, 1'b0, "mode_in3");
      drive(0, 0, 1, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b1, "sel_f");
      drive(0, 0, 0, 1, 1, 0, 3'b100, 3'b000, 3'b111, 2'd2, 1'b1, "rpt_k0");
      for (int k = 1; k <= 20; k++)
         drive(0, 0, 0, 0, 1, 1, (AR && k >= 8 && k % 4 == 0) ? 3'b100 : 3'b000,
               3'b000, AR ? 3'b111 : 3'b011, 2'd2, 1'b1, "rpt_hold");
      for (int k = 21; k <= 30; k++)
         drive(0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 2'd2, 1'b1, "rpt_stop");

      drive(0, 0, 0, 1, 1, 0, 3'b100, 3'b000, 3'b111, 2'd2, 1'b1, "rpt2_k0");
      for (int k = 1; k <= 11; k++)
         drive(0, 0, 0, 0, 1, 0, (AR && k == 8) ? 3'b100 : 3'b000,
               3'b000, 3'b111, 2'd2, 1'b1, "rpt2");
      // Reset lands mid-cycle, in the cycle where the next repeat is due.
      drive(1, 0, 0, 0, 1, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "rst_mid");
      #1;
      chk("rst_async_inc", inc, 0);
      chk("rst_async_act", adjact, 0);
      chk("rst_async_sel", sel, 0);
      drive(1, 0, 0, 1, 1, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "rst_hold");
      drive(0, 0, 0, 1, 1, 0, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "post_adj");
      for (int k = 1; k <= 12; k++)
         drive(0, 0, 0, 0, 1, 1, 3'b000, 3'b000, 3'b111, 2'd0, 1'b0, "post_rst");

      repeat (2) @(posedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
